// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader: accepts N*N grey pixels over a valid/ready handshake,
// binarises each against THRESH and presents it to the skeletonization
// controller for two cycles (ACCEPT/HOLD cadence) while we is high.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle frame load request (honoured only in IDLE)
//   in_valid, in_pixel  upstream pixel stream
//   in_ready            high only in ACCEPT
//   we                  high for the whole load (ACCEPT/HOLD)
//   data_out            binarised pixel (0 or 1, zero-extended)
//   pix_count           pixel index counter, stops at N*N-1
//   busy                high outside IDLE
//   frame_done          one-cycle pulse in DONE
module pixel_stream_loader #(
  parameter int unsigned N          = 8,
  parameter int unsigned pixelWidth = 8,
  parameter int unsigned bitSize    = $clog2(N*N),
  parameter int unsigned THRESH     = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [pixelWidth-1:0] in_pixel,
  output logic                  in_ready,
  output logic                  we,
  output logic [pixelWidth-1:0] data_out,
  output logic [bitSize-1:0]    pix_count,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned LAST = N*N - 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, HOLD, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_d, we_d, busy_d, frame_done_d;
  logic [pixelWidth-1:0]   data_out_d;
  logic [bitSize-1:0]      pix_count_d;
  logic                    last_pix;

  assign last_pix = (pix_count == bitSize'(LAST));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCEPT;
      ACCEPT:  if (in_valid) state_d = HOLD;
      HOLD:    state_d = last_pix ? DONE : ACCEPT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; status flags decode the upcoming state so they are registered
  always_comb begin
    pix_count_d  = pix_count;
    data_out_d   = data_out;
    unique case (state_q)
      IDLE:   if (start) pix_count_d = '0;
      ACCEPT: if (in_valid)
                data_out_d = (in_pixel >= pixelWidth'(THRESH)) ? pixelWidth'(1) : '0;
      HOLD:   if (!last_pix) pix_count_d = pix_count + bitSize'(1);
      default: ;
    endcase
    in_ready_d   = (state_d == ACCEPT);
    we_d         = (state_d == ACCEPT) || (state_d == HOLD);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      we         <= 1'b0;
      data_out   <= '0;
      pix_count  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      we         <= we_d;
      data_out   <= data_out_d;
      pix_count  <= pix_count_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Directed bench for pixel_stream_loader (N=8, pixelWidth=8, THRESH=128).
module tb_pixel_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic       we;
  logic [7:0] data_out;
  logic [5:0] pix_count;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  int xfer_cnt = 0;

  logic [7:0] pix [64];
  logic [7:0] expv[64];

  pixel_stream_loader #(.N(8), .pixelWidth(8), .THRESH(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .we(we), .data_out(data_out),
    .pix_count(pix_count), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Event monitors sampled on the falling edge
  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (we) we_cnt <= we_cnt + 1;
    if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame load with optional stall, abort (reset), restart attempt, start-in-DONE
  task automatic run_frame(input int stall_at, input int abort_at,
                           input int restart_at, input bit start_in_done);
    int d0, w0, t0, stall_len;
    d0 = done_cnt; w0 = we_cnt; t0 = xfer_cnt;
    stall_len = (stall_at >= 0) ? 5 : 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_we", we, 1);
    check("start_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_count", pix_count, 0);
    for (int k = 0; k < 64; k++) begin
      if (k == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_we", we, 0);
        check("abort_ready", in_ready, 0);
        check("abort_data", data_out, 0);
        check("abort_count", pix_count, 0);
        check("abort_busy", busy, 0);
        check("abort_done", frame_done, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_idle_busy", busy, 0);
        check("abort_idle_we", we, 0);
        check("abort_no_done", done_cnt - d0, 0);
        return;
      end
      if (k == stall_at) begin
        in_valid = 1'b0;
        repeat (5) begin
          tick();
          check("stall_ready", in_ready, 1);
          check("stall_count", pix_count, k);
          check("stall_data", data_out, expv[k-1]);
          check("stall_we", we, 1);
        end
      end
      in_valid = 1'b1;
      in_pixel = pix[k];
      if (k == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      check("hold_data", data_out, expv[k]);
      check("hold_ready", in_ready, 0);
      check("hold_count", pix_count, k);
      check("hold_we", we, 1);
      tick();
      if (k < 63) begin
        check("acc_count", pix_count, k + 1);
        check("acc_data", data_out, expv[k]);
        check("acc_ready", in_ready, 1);
      end else begin
        check("done_pulse", frame_done, 1);
        check("done_we", we, 0);
        check("done_count", pix_count, 63);
        check("done_ready", in_ready, 0);
        check("done_busy", busy, 1);
        check("done_data", data_out, expv[63]);
      end
    end
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_done", frame_done, 0);
    check("idle_busy", busy, 0);
    check("idle_we", we, 0);
    check("idle_count", pix_count, 63);
    check("idle_data", data_out, expv[63]);
    if (start_in_done) begin
      tick();
      check("done_start_ignored", busy, 0);
    end
    check("frame_done_once", done_cnt - d0, 1);
    check("we_cycles", we_cnt - w0, 128 + stall_len);
    check("transfers", xfer_cnt - t0, 64);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0;
    for (int k = 0; k < 64; k++) begin
      pix[k]  = (k % 2 == 0) ? 8'd200 : 8'd10;
      expv[k] = (k % 2 == 0) ? 8'd1 : 8'd0;
    end
    // Threshold boundaries: 128 -> 1, 127 -> 0, 255 -> 1, 0 -> 0
    pix[20] = 8'd128; pix[21] = 8'd127; pix[22] = 8'd255; pix[23] = 8'd0;
    #12;
    check("rst_we", we, 0);
    check("rst_ready", in_ready, 0);
    check("rst_data", data_out, 0);
    check("rst_count", pix_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_ready", in_ready, 0);
    check("idle_busy0", busy, 0);

    run_frame(-1, -1, -1, 1'b0);   // plain frame, threshold edges
    run_frame(-1, -1, -1, 1'b0);   // back-to-back frame
    run_frame(10, -1, -1, 1'b0);   // 5-cycle stall at pixel 10
    run_frame(-1, -1, 30, 1'b1);   // start during load and during DONE
    run_frame(-1, 40, -1, 1'b0);   // reset at pixel 40
    run_frame(-1, -1, -1, 1'b0);   // reload after abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pixel_stream_loader.md
PIXEL_STREAM_LOADER -- requirements
Module: pixel_stream_loader

Interface
REQ-001 SHALL have parameter N, default 8, image side length in pixels (frame = N*N pixels).
REQ-002 SHALL have parameter pixelWidth, default 8, bits per pixel on input and output.
REQ-003 SHALL have parameter bitSize, default $clog2(N*N), pixel-counter width; it is derived and SHALL NOT be overridden.
REQ-004 SHALL have parameter THRESH, default 128, binarisation threshold.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to load a new frame.
REQ-008 in_valid  input  1  upstream pixel valid.
REQ-009 in_pixel  input  pixelWidth  upstream raw grey pixel.
REQ-010 in_ready  output  1  loader can accept in_pixel this cycle.
REQ-011 we  output  1  write enable to the skeletonization controller; high for the whole load.
REQ-012 data_out  output  pixelWidth  binarised pixel presented to the controller.
REQ-013 pix_count  output  bitSize  index of the pixel currently on data_out.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel has been held.

Function
REQ-016 SHALL implement four states: IDLE, ACCEPT, HOLD, DONE.
REQ-017 IDLE: in_ready=0, we=0; start=1 SHALL move the block to ACCEPT on the next edge, clear pix_count, and set we=1.
REQ-018 ACCEPT: in_ready SHALL be 1; in_valid=0 SHALL leave the block in ACCEPT with data_out and we unchanged (stall, no count advance).
REQ-019 ACCEPT with in_valid=1: transfer SHALL occur; on the next edge data_out SHALL equal 1 if in_pixel >= THRESH, else 0 (zero-extended to pixelWidth), and the state SHALL become HOLD.
REQ-020 HOLD: in_ready=0; the state SHALL last exactly one cycle, so each pixel is stable on data_out for 2 cycles (the controller's two-clock write cadence).
REQ-021 On leaving HOLD with pix_count < N*N-1, pix_count SHALL increment by 1 and the state SHALL become ACCEPT.
REQ-022 On leaving HOLD with pix_count == N*N-1, pix_count SHALL NOT wrap; the state SHALL become DONE and we SHALL fall to 0 on that edge.
REQ-023 DONE: frame_done=1 for exactly one cycle; the state then SHALL become IDLE; data_out SHALL hold the last pixel.
REQ-024 start while busy=1 SHALL be ignored (no restart, no count change).
REQ-025 start asserted during the DONE cycle SHALL be ignored; a new frame requires start in IDLE.
REQ-026 The comparison in_pixel >= THRESH SHALL be unsigned at pixelWidth bits; THRESH=0 maps every pixel to 1.
REQ-027 Exactly N*N transfers SHALL be accepted per frame; in_ready SHALL never be 1 outside ACCEPT.

Reset
REQ-028 rst_n=0 SHALL force, asynchronously: state=IDLE, we=0, in_ready=0, data_out=0, pix_count=0, busy=0, frame_done=0.
REQ-029 Reset during a load SHALL abandon the frame with no frame_done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-030 N=8, start, in_valid held 1, in_pixel alternating 200/10 -> data_out 1,0,1,0..., each value held 2 cycles, we high for 128 cycles, frame_done pulses once, pix_count ends at 63.
REQ-031 in_valid deasserted for 5 cycles at pixel 10 -> in_ready stays 1, pix_count stays 10, data_out unchanged, load completes with 64 transfers.
REQ-032 in_pixel=128 and then 127 with THRESH=128 -> data_out=1, then data_out=0.
REQ-033 start pulsed again at pixel 30 -> ignored; count continues 31..63, single frame_done.
REQ-034 rst_n low at pixel 40 for 1 cycle -> all outputs 0 immediately, no frame_done; new start reloads from pix_count=0.
REQ-035 Two back-to-back frames (start on the first IDLE cycle after frame_done) -> second frame identical in timing, pix_count restarts at 0.
